// File: rtl/id_hazard_ctrl_if.sv
// Decode-to-execute hazard control bus.
// Carries the decoded-instruction fields into the hazard controller and the
// skip / bubble / forwarding selects and performance counters back out.
//   master : decode stage (drives instruction fields, observes controls)
//   slave  : id_hazard_ctrl (observes instruction fields, drives controls)
interface id_hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 instr_valid;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic                 rs1_used;
  logic                 rs2_used;
  logic [4:0]           rd_addr;
  logic                 writeback_en;
  logic                 writeback_from_mem;
  logic                 branch_taken;
  logic                 skip;
  logic                 skip_instr;
  logic                 rs1_take_prev1;
  logic                 rs2_take_prev1;
  logic                 rs1_take_prev2;
  logic                 rs2_take_prev2;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output instr_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
           rd_addr, writeback_en, writeback_from_mem, branch_taken,
    input  skip, skip_instr, rs1_take_prev1, rs2_take_prev1,
           rs1_take_prev2, rs2_take_prev2, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
           rd_addr, writeback_en, writeback_from_mem, branch_taken,
    output skip, skip_instr, rs1_take_prev1, rs2_take_prev1,
           rs1_take_prev2, rs2_take_prev2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller.
// Tracks the destination registers of the two instructions ahead of decode
// (EX and MEM/WB), selects operand forwarding, inserts a one-cycle stall on a
// load-use dependency, squashes FLUSH_CYCLES decode slots after a taken
// branch, and keeps saturating stall / squash counters.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : id_hazard_ctrl_if.slave (decoded fields in, skip/bubble/forward
//          selects and counters out)
module id_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wb_en;
    logic       from_mem;
  } hist_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  hist_t                r_p1;
  hist_t                r_p2;
  logic [2:0]           r_flush_left;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_live_rs1;
  logic w_live_rs2;
  logic w_hit1_rs1;
  logic w_hit1_rs2;
  logic w_hit2_rs1;
  logic w_hit2_rs2;
  logic w_flushing;
  logic w_load_use;
  logic w_issue;

  logic w_skip;
  logic w_skip_instr;
  logic w_rs1_p1;
  logic w_rs2_p1;
  logic w_rs1_p2;
  logic w_rs2_p2;

  // Hazard classification; x0 sources never match so rd==0 producers are inert
  always_comb begin
    w_live_rs1 = bus.rs1_used & (bus.rs1_addr != '0);
    w_live_rs2 = bus.rs2_used & (bus.rs2_addr != '0);
    w_hit1_rs1 = w_live_rs1 & r_p1.valid & r_p1.wb_en & (r_p1.rd == bus.rs1_addr);
    w_hit1_rs2 = w_live_rs2 & r_p1.valid & r_p1.wb_en & (r_p1.rd == bus.rs2_addr);
    w_hit2_rs1 = w_live_rs1 & r_p2.valid & r_p2.wb_en & (r_p2.rd == bus.rs1_addr);
    w_hit2_rs2 = w_live_rs2 & r_p2.valid & r_p2.wb_en & (r_p2.rd == bus.rs2_addr);
    w_flushing = bus.branch_taken | (r_flush_left != '0);
    // A flush outranks the stall, so a squashed consumer never counts a stall
    w_load_use = ~w_flushing & bus.instr_valid & (w_hit1_rs1 | w_hit1_rs2) & r_p1.from_mem;
    w_issue    = ~w_flushing & bus.instr_valid & ~w_load_use;
  end

  // Pipeline controls; forced to a bubble while reset is asserted
  always_comb begin
    w_skip       = 1'b0;
    w_skip_instr = 1'b1;
    w_rs1_p1     = 1'b0;
    w_rs2_p1     = 1'b0;
    w_rs1_p2     = 1'b0;
    w_rs2_p2     = 1'b0;
    if (rst) begin
      w_skip       = w_load_use;
      w_skip_instr = ~w_issue;
      if (w_issue) begin
        w_rs1_p1 = w_hit1_rs1;
        w_rs2_p1 = w_hit1_rs2;
        // The younger (EX) producer wins over the MEM/WB one
        w_rs1_p2 = w_hit2_rs1 & ~w_hit1_rs1;
        w_rs2_p2 = w_hit2_rs2 & ~w_hit1_rs2;
      end
    end
  end

  assign bus.skip           = w_skip;
  assign bus.skip_instr     = w_skip_instr;
  assign bus.rs1_take_prev1 = w_rs1_p1;
  assign bus.rs2_take_prev1 = w_rs2_p1;
  assign bus.rs1_take_prev2 = w_rs1_p2;
  assign bus.rs2_take_prev2 = w_rs2_p2;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.flush_cnt      = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p1         <= '0;
      r_p2         <= '0;
      r_flush_left <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_p2 <= r_p1;
      if (w_issue) begin
        r_p1 <= {1'b1, bus.rd_addr, bus.writeback_en, bus.writeback_from_mem};
      end else begin
        r_p1.valid <= 1'b0;
      end

      // A re-pulse during a flush restarts the squash window
      if (bus.branch_taken) begin
        r_flush_left <= FLUSH_LOAD;
      end else if (r_flush_left != '0) begin
        r_flush_left <= r_flush_left - 3'd1;
      end

      if (w_load_use && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flushing && bus.instr_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule
